// File: rtl/store_fwd_pkg.sv
// ---------------------------------------------------------------------------
// store_fwd_pkg
// Shared types for the store-data forwarding unit.
//   fwd_src_e   : EX store-data source select (REG / MEM / WB / HIST)
//   stage_ent_t : in-flight producer record for the MEM and WB stages
//   hist_ent_t  : one retained WB write {valid, rd, data}
//   sat_inc32   : saturating 32-bit increment used by the statistics counter
// The struct field widths follow SF_DATA_W / SF_REG_AW; the DATA_W and
// REG_AW parameters of the units must be left at these values.
// ---------------------------------------------------------------------------
package store_fwd_pkg;

   localparam int SF_DATA_W = 32;
   localparam int SF_REG_AW = 5;

   typedef enum logic [1:0] {
      SRC_REG  = 2'd0,
      SRC_MEM  = 2'd1,
      SRC_WB   = 2'd2,
      SRC_HIST = 2'd3
   } fwd_src_e;

   typedef struct packed {
      logic                 valid;
      logic                 we;
      logic                 is_load;
      logic [SF_REG_AW-1:0] rd;
   } stage_ent_t;

   typedef struct packed {
      logic                 valid;
      logic [SF_REG_AW-1:0] rd;
      logic [SF_DATA_W-1:0] data;
   } hist_ent_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/store_fwd_hist.sv
// ---------------------------------------------------------------------------
// store_fwd_hist
// Shift register of the most recent register-file writes, with a
// newest-first lookup. Entry 0 is the newest; the oldest drops out on push.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (clears all entries)
//   push         : record {push_rd, push_data} this edge
//   push_rd      : destination register of the write (never 0)
//   push_data    : value written
//   lookup_rd    : register being searched for
//   hit          : some valid entry holds lookup_rd
//   hit_data     : data of the newest matching entry (0 on miss)
// ---------------------------------------------------------------------------
import store_fwd_pkg::*;

module store_fwd_hist #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = SF_DATA_W,
   parameter int REG_AW = SF_REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [REG_AW-1:0] push_rd,
   input  logic [DATA_W-1:0] push_data,
   input  logic [REG_AW-1:0] lookup_rd,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data
);

   hist_ent_t ent [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else if (push) begin
         ent[0].valid <= 1'b1;
         ent[0].rd    <= push_rd;
         ent[0].data  <= push_data;
         for (int i = 1; i < DEPTH; i++) ent[i] <= ent[i-1];
      end
   end

   // Scan oldest to newest so a newer match overwrites an older one.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ent[i].valid && (ent[i].rd == lookup_rd)) begin
            hit      = 1'b1;
            hit_data = ent[i].data;
         end
      end
   end

endmodule

// File: rtl/store_fwd_unit.sv
// ---------------------------------------------------------------------------
// store_fwd_unit
// Store-data forwarding for the 5-stage pipeline. Tracks producers in MEM
// and WB, keeps a short history of WB writes, resolves store data early in
// EX and late in MEM (load followed by a store of the loaded register), and
// owns the MEM-stage store-data register.
// Optional feature macro: STORE_FWD_STATS_EN (forward-event counter).
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   stall, flush     : EX frozen / EX killed; either sends a bubble to MEM
//   ex_valid         : EX holds a real instruction
//   ex_reg_write     : EX writes ex_rd
//   ex_is_load       : EX is a load
//   ex_rd            : EX destination register
//   ex_is_store      : EX is a store
//   ex_rt            : store source register
//   ex_reg2          : register-file value of ex_rt
//   mem_alu_result   : ALU result of the MEM-stage instruction
//   wb_data          : value being written back in WB
//   ex_store_data    : forwarded store data in EX (combinational)
//   ex_fwd_src       : EX source select (fwd_src_e encoding)
//   mem_store_data   : store data presented to data memory in MEM
//   mem_late_fwd     : MEM store data is taken from wb_data
//   fwd_count        : saturating forward-event count (0 when disabled)
// Pipeline control: an EX instruction advances into MEM only when
// ex_valid & !stall & !flush; otherwise MEM receives a bubble. MEM always
// moves to WB and the history always advances.
// ---------------------------------------------------------------------------
import store_fwd_pkg::*;

module store_fwd_unit #(
   parameter int DATA_W     = SF_DATA_W,
   parameter int REG_AW     = SF_REG_AW,
   parameter int HIST_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic              ex_reg_write,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_is_store,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic [DATA_W-1:0] ex_reg2,
   input  logic [DATA_W-1:0] mem_alu_result,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [1:0]        ex_fwd_src,
   output logic [DATA_W-1:0] mem_store_data,
   output logic              mem_late_fwd,
   output logic [31:0]       fwd_count
);

   stage_ent_t        mem_q;
   stage_ent_t        wb_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              late_q;

   logic              advance;
   logic              rt_nz;
   logic              mem_hit;
   logic              wb_hit;
   logic              hist_push;
   logic              hist_hit;
   logic [DATA_W-1:0] hist_data;
   logic              late;
   fwd_src_e          src;

   assign advance   = ex_valid & ~stall & ~flush;
   assign rt_nz     = (ex_rt != '0);
   assign mem_hit   = mem_q.valid & mem_q.we & (mem_q.rd == ex_rt);
   assign wb_hit    = wb_q.valid & wb_q.we & (wb_q.rd == ex_rt);
   assign hist_push = wb_q.valid & wb_q.we & (wb_q.rd != '0);

   store_fwd_hist #(
      .DEPTH  (HIST_DEPTH),
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_hist (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (hist_push),
      .push_rd   (wb_q.rd),
      .push_data (wb_data),
      .lookup_rd (ex_rt),
      .hit       (hist_hit),
      .hit_data  (hist_data)
   );

   // A load in MEM has no data yet: EX passes the stale register value and
   // flags the store so the MEM stage substitutes wb_data one cycle later.
   always_comb begin
      src           = SRC_REG;
      ex_store_data = ex_reg2;
      late          = 1'b0;
      if (rt_nz) begin
         if (mem_hit && !mem_q.is_load) begin
            src           = SRC_MEM;
            ex_store_data = mem_alu_result;
         end else if (mem_hit) begin
            late = 1'b1;
         end else if (wb_hit) begin
            src           = SRC_WB;
            ex_store_data = wb_data;
         end else if (hist_hit) begin
            src           = SRC_HIST;
            ex_store_data = hist_data;
         end
      end
   end

   assign ex_fwd_src = src;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         wb_q <= mem_q;
         if (advance) begin
            mem_q.valid   <= 1'b1;
            mem_q.we      <= ex_reg_write;
            mem_q.is_load <= ex_is_load;
            mem_q.rd      <= ex_rd;
         end else begin
            mem_q.valid <= 1'b0;
         end
      end
   end

   // A bubble keeps the last store data but must never carry a late flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_wdata_q <= '0;
         late_q      <= 1'b0;
      end else if (advance) begin
         mem_wdata_q <= ex_store_data;
         late_q      <= late & ex_is_store;
      end else begin
         late_q <= 1'b0;
      end
   end

   assign mem_store_data = late_q ? wb_data : mem_wdata_q;
   assign mem_late_fwd   = late_q;

`ifdef STORE_FWD_STATS_EN
   logic [31:0] fwd_cnt_q;
   logic        fwd_event;

   assign fwd_event = advance & ex_is_store & ((src != SRC_REG) | late);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwd_cnt_q <= '0;
      end else if (fwd_event) begin
         fwd_cnt_q <= sat_inc32(fwd_cnt_q);
      end
   end

   assign fwd_count = fwd_cnt_q;
`else
   assign fwd_count = '0;
`endif

endmodule

// File: tb/tb_store_fwd_unit.sv
// ---------------------------------------------------------------------------
// tb_store_fwd_unit
// Directed bench for store_fwd_unit. A second instance with HIST_DEPTH=1
// shares all inputs so the history depth boundary can be observed.
// MEM-stage expectations are queued when a store advances and popped on
// the following cycle.
// ---------------------------------------------------------------------------
module tb_store_fwd_unit;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          stall, flush;
   logic          ex_valid, ex_reg_write, ex_is_load, ex_is_store;
   logic [AW-1:0] ex_rd, ex_rt;
   logic [DW-1:0] ex_reg2, mem_alu_result, wb_data;

   logic [DW-1:0] ex_store_data, mem_store_data;
   logic [1:0]    ex_fwd_src;
   logic          mem_late_fwd;
   logic [31:0]   fwd_count;

   logic [DW-1:0] h1_ex_store_data, h1_mem_store_data;
   logic [1:0]    h1_ex_fwd_src;
   logic          h1_mem_late_fwd;
   logic [31:0]   h1_fwd_count;

   int            checks = 0;
   int            errors = 0;
   int            exp_fwd = 0;
   bit            stats_on;
   logic [DW:0]   exp_q[$];

   store_fwd_unit #(.DATA_W(DW), .REG_AW(AW), .HIST_DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .flush          (flush),
      .ex_valid       (ex_valid),
      .ex_reg_write   (ex_reg_write),
      .ex_is_load     (ex_is_load),
      .ex_rd          (ex_rd),
      .ex_is_store    (ex_is_store),
      .ex_rt          (ex_rt),
      .ex_reg2        (ex_reg2),
      .mem_alu_result (mem_alu_result),
      .wb_data        (wb_data),
      .ex_store_data  (ex_store_data),
      .ex_fwd_src     (ex_fwd_src),
      .mem_store_data (mem_store_data),
      .mem_late_fwd   (mem_late_fwd),
      .fwd_count      (fwd_count)
   );

   store_fwd_unit #(.DATA_W(DW), .REG_AW(AW), .HIST_DEPTH(1)) dut_h1 (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .flush          (flush),
      .ex_valid       (ex_valid),
      .ex_reg_write   (ex_reg_write),
      .ex_is_load     (ex_is_load),
      .ex_rd          (ex_rd),
      .ex_is_store    (ex_is_store),
      .ex_rt          (ex_rt),
      .ex_reg2        (ex_reg2),
      .mem_alu_result (mem_alu_result),
      .wb_data        (wb_data),
      .ex_store_data  (h1_ex_store_data),
      .ex_fwd_src     (h1_ex_fwd_src),
      .mem_store_data (h1_mem_store_data),
      .mem_late_fwd   (h1_mem_late_fwd),
      .fwd_count      (h1_fwd_count)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic set_ex(input logic v, input logic rw, input logic ld,
                         input logic [AW-1:0] rd, input logic st,
                         input logic [AW-1:0] rt, input logic [DW-1:0] reg2);
      ex_valid     = v;
      ex_reg_write = rw;
      ex_is_load   = ld;
      ex_rd        = rd;
      ex_is_store  = st;
      ex_rt        = rt;
      ex_reg2      = reg2;
   endtask

   task automatic set_idle();
      set_ex(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
      stall = 1'b0;
      flush = 1'b0;
   endtask

   task automatic set_aux(input logic [DW-1:0] alu, input logic [DW-1:0] wb);
      mem_alu_result = alu;
      wb_data        = wb;
      #1;
   endtask

   // Advance one clock; inputs for the next cycle are applied 1 time unit
   // after the edge, outputs are checked after they settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_ex(input string tag, input logic [1:0] src, input logic [DW-1:0] data);
      chk({tag, "_src"}, 64'(ex_fwd_src), 64'(src));
      chk({tag, "_data"}, 64'(ex_store_data), 64'(data));
   endtask

   task automatic push_mem(input logic late, input logic [DW-1:0] data);
      exp_q.push_back({late, data});
   endtask

   task automatic pop_mem(input string tag);
      logic [DW:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_late"}, 64'(mem_late_fwd), 64'(e[DW]));
         chk({tag, "_data"}, 64'(mem_store_data), 64'(e[DW-1:0]));
      end
   endtask

   task automatic chk_count(input string tag);
      chk(tag, 64'(fwd_count), stats_on ? 64'(exp_fwd) : 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
`ifdef STORE_FWD_STATS_EN
      stats_on = 1'b1;
`else
      stats_on = 1'b0;
`endif
      rst_n = 1'b0;
      set_idle();
      set_aux(32'h0, 32'h0);
      tick();
      tick();

      // Reset state: nothing in flight, store data falls back to ex_reg2.
      rst_n = 1'b1;
      set_ex(1'b0, 1'b0, 1'b0, '0, 1'b1, 5'd5, 32'h55);
      set_aux(32'h0, 32'h0);
      chk("rst_mem_data", 64'(mem_store_data), 64'h0);
      chk("rst_late", 64'(mem_late_fwd), 64'h0);
      chk_count("rst_count");
      chk_ex("rst_ex", 2'd0, 32'h55);
      tick();

      // add r5 then sw r5: forward from MEM ALU result.
      set_ex(1'b1, 1'b1, 1'b0, 5'd5, 1'b0, '0, '0);
      set_aux(32'h0, 32'h0);
      tick();
      set_ex(1'b1, 1'b0, 1'b0, '0, 1'b1, 5'd5, 32'h0);
      set_aux(32'h11, 32'h0);
      chk_ex("mem_fwd", 2'd1, 32'h11);
      push_mem(1'b0, 32'h11);
      exp_fwd++;
      tick();
      set_idle();
      set_aux(32'h0, 32'h11);
      pop_mem("mem_fwd_m");

      // lw r6 then sw r6: late forward of the load result in MEM.
      tick();
      set_ex(1'b1, 1'b1, 1'b1, 5'd6, 1'b0, '0, '0);
      set_aux(32'h0, 32'h0);
      tick();
      set_ex(1'b1, 1'b0, 1'b0, '0, 1'b1, 5'd6, 32'h1234);
      set_aux(32'h0, 32'h0);
      chk_ex("late_ex", 2'd0, 32'h1234);
      push_mem(1'b1, 32'hDEAD_BEEF);
      exp_fwd++;
      tick();
      set_idle();
      set_aux(32'h0, 32'hDEAD_BEEF);
      pop_mem("late_m");
      chk_count("count_a");

      // r7=0xA then r8=0xB written back; sw r7 reaches the older entry.
      tick();
      set_ex(1'b1, 1'b1, 1'b0, 5'd7, 1'b0, '0, '0);
      set_aux(32'h0, 32'h0);
      tick();
      set_ex(1'b1, 1'b1, 1'b0, 5'd8, 1'b0, '0, '0);
      set_aux(32'hA, 32'h0);
      tick();
      set_idle();
      set_aux(32'hB, 32'hA);
      tick();
      set_aux(32'h0, 32'hB);
      tick();
      set_ex(1'b1, 1'b0, 1'b0, '0, 1'b1, 5'd7, 32'h0);
      set_aux(32'h0, 32'h0);
      chk_ex("hist_old", 2'd3, 32'hA);
      chk("hist_d1_src", 64'(h1_ex_fwd_src), 64'd0);
      chk("hist_d1_data", 64'(h1_ex_store_data), 64'h0);
      push_mem(1'b0, 32'hA);
      exp_fwd++;
      tick();
      set_ex(1'b1, 1'b0, 1'b0, '0, 1'b1, 5'd8, 32'h0);
      set_aux(32'h0, 32'h0);
      pop_mem("hist_old_m");
      chk_ex("hist_new", 2'd3, 32'hB);
      chk("hist_d1_new_src", 64'(h1_ex_fwd_src), 64'd3);
      push_mem(1'b0, 32'hB);
      exp_fwd++;
      tick();
      set_idle();
      set_aux(32'h0, 32'h0);
      pop_mem("hist_new_m");
      chk_count("count_b");

      // Register 0 is never forwarded, even with a matching MEM producer.
      tick();
      set_ex(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, '0, '0);
      set_aux(32'h0, 32'h0);
      tick();
      set_ex(1'b1, 1'b0, 1'b0, '0, 1'b1, 5'd0, 32'h77);
      set_aux(32'h99, 32'h0);
      chk_ex("r0", 2'd0, 32'h77);
      push_mem(1'b0, 32'h77);
      tick();
      set_idle();
      set_aux(32'h0, 32'h99);
      pop_mem("r0_m");

      // lw r9 then sw r9 with a one-cycle stall: resolves from WB instead.
      tick();
      set_ex(1'b1, 1'b1, 1'b1, 5'd9, 1'b0, '0, '0);
      set_aux(32'h0, 32'h0);
      tick();
      set_ex(1'b1, 1'b0, 1'b0, '0, 1'b1, 5'd9, 32'h1);
      stall = 1'b1;
      set_aux(32'h0, 32'h0);
      chk_ex("stall_ex", 2'd0, 32'h1);
      tick();
      stall = 1'b0;
      set_aux(32'h0, 32'hCAFE);
      chk("stall_bubble_late", 64'(mem_late_fwd), 64'h0);
      chk("stall_bubble_data", 64'(mem_store_data), 64'h0);
      chk_ex("stall_wb", 2'd2, 32'hCAFE);
      push_mem(1'b0, 32'hCAFE);
      exp_fwd++;
      tick();
      set_idle();
      set_aux(32'h0, 32'h0);
      pop_mem("stall_m");
      chk_count("count_c");

      // stall and flush together: the add r10 never reaches MEM.
      tick();
      set_ex(1'b1, 1'b1, 1'b0, 5'd10, 1'b0, '0, '0);
      stall = 1'b1;
      flush = 1'b1;
      set_aux(32'h0, 32'h0);
      tick();
      stall = 1'b0;
      flush = 1'b0;
      set_ex(1'b1, 1'b0, 1'b0, '0, 1'b1, 5'd10, 32'h42);
      set_aux(32'h10, 32'h0);
      chk_ex("flush", 2'd0, 32'h42);
      push_mem(1'b0, 32'h42);
      tick();
      set_idle();
      set_aux(32'h0, 32'h0);
      pop_mem("flush_m");

      // Reset with a late store in MEM and a load in WB.
      tick();
      set_ex(1'b1, 1'b1, 1'b1, 5'd11, 1'b0, '0, '0);
      set_aux(32'h0, 32'h0);
      tick();
      set_ex(1'b1, 1'b0, 1'b0, '0, 1'b1, 5'd11, 32'h5);
      set_aux(32'h0, 32'h0);
      exp_fwd++;
      tick();
      set_idle();
      rst_n = 1'b0;
      set_aux(32'h0, 32'hFEED);
      chk("pre_rst_late", 64'(mem_late_fwd), 64'h1);
      chk("pre_rst_data", 64'(mem_store_data), 64'hFEED);
      chk_count("count_d");
      tick();
      rst_n = 1'b1;
      exp_fwd = 0;
      set_ex(1'b1, 1'b0, 1'b0, '0, 1'b1, 5'd11, 32'h3);
      set_aux(32'h0, 32'h1);
      chk("post_rst_data", 64'(mem_store_data), 64'h0);
      chk("post_rst_late", 64'(mem_late_fwd), 64'h0);
      chk_count("post_rst_count");
      chk_ex("post_rst_ex", 2'd0, 32'h3);
      push_mem(1'b0, 32'h3);
      tick();
      set_idle();
      set_aux(32'h0, 32'h0);
      pop_mem("post_rst_m");
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_fwd_unit.md
Name: store_fwd_unit

Overview:
Parametrised store-data forwarding unit for the 5-stage MIPS pipeline, replacing the fixed EX/MEM two-way store-data muxes. It tracks in-flight producers in MEM and WB and keeps a short history of recent WB writes. It resolves store-data hazards at two points: early, in EX, from MEM/WB/history; late, in MEM, for load-to-store dependences. It also owns the MEM-stage store-data register, so load→store sequences never need a stall.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width; register 0 is never forwarded
HIST_DEPTH, 2, number of past WB writes retained (1..8)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  synchronous active-low reset
stall  in  1  EX frozen this cycle; bubble enters MEM; MEM→WB and history still advance
flush  in  1  kill EX instruction; bubble enters MEM
ex_valid  in  1  EX holds a real instruction
ex_reg_write  in  1  EX instruction writes rd
ex_is_load  in  1  EX instruction is a load
ex_rd  in  REG_AW  EX destination register
ex_is_store  in  1  EX instruction is a store
ex_rt  in  REG_AW  store source register
ex_reg2  in  DATA_W  register-file read value of rt
mem_alu_result  in  DATA_W  MEM-stage ALU result
wb_data  in  DATA_W  final WB write value (ALU or load data)
ex_store_data  out  DATA_W  forwarded store data in EX (combinational)
ex_fwd_src  out  2  EX source select, encoded as fwd_src_e
mem_store_data  out  DATA_W  data to data memory in MEM
mem_late_fwd  out  1  MEM store data taken from wb_data
fwd_count  out  32  forward-event counter (optional feature)

Behaviour:
- Scoreboard registers, MEM and WB stages, each holding {valid, we, is_load, rd}.
  - On each edge: WB ← MEM.
  - MEM ← EX fields when ex_valid & !stall & !flush; otherwise MEM.valid ← 0.
- History buffer: shift register of {valid, rd, data}.
  - On each edge with WB.valid & WB.we & WB.rd≠0, push {WB.rd, wb_data}; the oldest entry drops out.
  - Lookups give the newest entry priority.
- EX select for rt≠0, highest priority first:
  1. MEM producer (valid, we, rd==rt, !is_load) → SRC_MEM, mem_alu_result.
  2. MEM producer is a load with rd==rt → late flag set; ex_store_data = ex_reg2, SRC_REG.
  3. WB producer match → SRC_WB, wb_data.
  4. History hit → SRC_HIST, entry data.
  5. Otherwise → SRC_REG, ex_reg2.
  - rt==0 always gives SRC_REG.
- MEM registers: mem_wdata_q ← ex_store_data and late_q ← (late flag & ex_is_store), loaded under the same advance condition as the scoreboard. A bubble clears late_q and holds mem_wdata_q.
- mem_store_data = late_q ? wb_data : mem_wdata_q. mem_late_fwd = late_q. Latency is 1 cycle from EX to MEM.
- Stall with a load in MEM: next cycle the load is in WB and the store stays in EX, so the EX select now resolves SRC_WB.
- stall and flush together: flush wins, and the result is identical to a bubble.
- Reset, synchronous while rst_n=0:
  - all valid bits cleared;
  - mem_wdata_q = 0, late_q = 0, history data = 0;
  - mem_store_data = 0 and ex_fwd_src = SRC_REG (ex_store_data = ex_reg2);
  - fwd_count = 0.
  - Reset mid-operation discards all in-flight state.

Optional Feature:
STORE_FWD_STATS_EN:
- Defined: fwd_count increments by 1 on each cycle with ex_valid & ex_is_store & !stall & !flush & (src≠SRC_REG or late flag). It saturates at 0xFFFFFFFF and clears on reset.
- Undefined: no counter logic; fwd_count is tied to 0.

Decomposition:
- Package store_fwd_pkg:
  - fwd_src_e (SRC_REG=0, SRC_MEM=1, SRC_WB=2, SRC_HIST=3);
  - stage_ent_t {valid, we, is_load, rd};
  - hist_ent_t {valid, rd, data}.
- Sub-module store_fwd_hist: history shift register plus newest-first lookup, parametrised by HIST_DEPTH.

Test Plan:
- add r5 (0x11) in MEM, sw r5 in EX → ex_fwd_src=1, ex_store_data=0x11; next cycle mem_store_data=0x11, mem_late_fwd=0.
- lw r6 in MEM, sw r6 in EX, no stall → next cycle mem_late_fwd=1, mem_store_data=wb_data (0xDEADBEEF).
- r7=0xA written in WB 2 cycles earlier, regfile stale ex_reg2=0 → SRC_HIST, ex_store_data=0xA. HIST_DEPTH=1 with write 2 cycles back → SRC_REG.
- sw r0 with MEM producer rd=0 → SRC_REG, ex_store_data=ex_reg2.
- lw r6 in MEM, sw r6 in EX, stall=1 for 1 cycle → cycle after: SRC_WB from the load result; MEM bubble with late_q=0; then normal advance.
- Reset asserted with late_q=1 and valid stages → after edge: mem_store_data=0, mem_late_fwd=0, fwd_count=0; a matching store then gives SRC_REG.
